count_fifo: RTL and testbench

Buffers the 4-bit value stream produced by the free-running counter so a slower consumer can drain it with a valid/ready handshake. Sits directly downstream of the counter stage: the counter output drives `in_data`, and `in_valid` is either tied high or driven by a sample strobe. A sticky overflow flag and a saturating drop counter record samples lost while the buffer is full.

---
 rtl/count_fifo.sv | 87 ++++++++
 tb/tb_count_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/count_fifo.sv
// Small FIFO buffering the free-running counter stream for a slower valid/ready consumer.
// One-cycle write-to-read latency; when full, incoming samples are dropped, flagged and counted.
module count_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [7:0]               dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;

  // Status flags come from registered level only, so no input-to-output paths.
  assign full      = (level == FULL_LEVEL);
  assign empty     = (level == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign drop = in_valid && full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Loss bookkeeping is sticky; only reset clears it, and the count pins at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      dropped  <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (dropped != 8'hff) dropped <= dropped + 8'd1;
    end
  end

endmodule

// File: tb/tb_count_fifo.sv
// Randomized and directed checks of count_fifo against a queue-based reference model.
module tb_count_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [2:0]       level;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [7:0]       dropped;

  count_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level), .full(full), .empty(empty),
    .overflow(overflow), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of stored samples plus loss bookkeeping.
  int q[$];
  int m_ovf = 0;
  int m_drp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf = 0;
    m_drp = 0;
  endtask

  task automatic model_edge(input logic iv, input int d, input logic ord);
    int pre = q.size();
    if (ord && pre > 0) void'(q.pop_front());
    if (iv) begin
      if (pre < DEPTH) q.push_back(d);
      else begin
        m_ovf = 1;
        if (m_drp < 255) m_drp++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".level"}, 32'(level), q.size());
    check({tag, ".full"}, 32'(full), (q.size() == DEPTH) ? 1 : 0);
    check({tag, ".empty"}, 32'(empty), (q.size() == 0) ? 1 : 0);
    check({tag, ".in_ready"}, 32'(in_ready), (q.size() < DEPTH) ? 1 : 0);
    check({tag, ".out_valid"}, 32'(out_valid), (q.size() > 0) ? 1 : 0);
    if (q.size() > 0) check({tag, ".out_data"}, 32'(out_data), q[0]);
    check({tag, ".overflow"}, 32'(overflow), m_ovf);
    check({tag, ".dropped"}, 32'(dropped), m_drp);
  endtask

  // Called at a falling edge; drives inputs, advances one clock, checks at the next falling edge.
  task automatic step(input string tag, input logic iv, input int d, input logic ord);
    in_valid  = iv;
    in_data   = WIDTH'(d);
    out_ready = ord;
    @(posedge clk);
    model_edge(iv, d, ord);
    @(negedge clk);
    check_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check({tag, ".rst_empty"}, 32'(empty), 1);
    check({tag, ".rst_in_ready"}, 32'(in_ready), 1);
    check({tag, ".rst_out_valid"}, 32'(out_valid), 0);
    check({tag, ".rst_level"}, 32'(level), 0);
    check({tag, ".rst_overflow"}, 32'(overflow), 0);
    check({tag, ".rst_dropped"}, 32'(dropped), 0);
    check({tag, ".rst_out_data"}, 32'(out_data), 0);
    @(negedge clk);
    reset = 1'b0;
    check_all(tag);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    check("init_out_data", 32'(out_data), 0);
    reset = 1'b0;
    check_all("init");

    // Fill then drain in order.
    for (int i = 1; i <= 4; i++) step("fill", 1'b1, i, 1'b0);
    check("fill_full", 32'(full), 1);
    check("fill_level", 32'(level), 4);
    for (int i = 1; i <= 4; i++) begin
      check("drain_val", 32'(out_data), i);
      step("drain", 1'b0, 0, 1'b1);
    end
    check("drain_empty", 32'(empty), 1);

    // Counter feed across the 4-bit wrap.
    for (int i = 0; i < 20; i++) begin
      step("feed", 1'b1, i % 16, 1'b1);
      check("feed_lvl_le1", (level <= 3'd1) ? 32'd1 : 32'd0, 1);
    end
    check("feed_ovf", 32'(overflow), 0);
    for (int i = 0; i < 2; i++) step("feed_flush", 1'b0, 0, 1'b1);

    // Overflow: three drops leave contents untouched.
    for (int i = 0; i < 7; i++) step("ovf", 1'b1, 10 + i, 1'b0);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_dropped", 32'(dropped), 3);
    check("ovf_head", 32'(out_data), 10);

    // Full with a simultaneous pop: the incoming 9 is still dropped.
    step("fullpop", 1'b1, 9, 1'b1);
    check("fullpop_level", 32'(level), 3);
    check("fullpop_dropped", 32'(dropped), 4);
    for (int i = 11; i <= 13; i++) begin
      check("fullpop_order", 32'(out_data), i);
      step("fullpop_drain", 1'b0, 0, 1'b1);
    end

    // Saturation of the drop counter.
    for (int i = 0; i < 4; i++) step("sat_fill", 1'b1, i + 1, 1'b0);
    for (int i = 0; i < 300; i++) step("sat", 1'b1, 7, 1'b0);
    check("sat_dropped", 32'(dropped), 255);
    for (int i = 0; i < 2; i++) step("sat_pop", 1'b0, 0, 1'b1);
    check("pre_reset_level", 32'(level), 2);
    reset_pulse("midrst");
    step("post_rst_push", 1'b1, 5, 1'b0);
    check("post_rst_data", 32'(out_data), 5);
    check("post_rst_valid", 32'(out_valid), 1);

    // Randomized traffic with shifting producer/consumer balance.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 500; i++) begin
        logic iv, ord;
        iv  = ($urandom_range(0, 3) < 3 - (ph % 2)) ? 1'b1 : 1'b0;
        ord = ($urandom_range(0, 3) < 1 + ph) ? 1'b1 : 1'b0;
        if ($urandom_range(0, 399) == 0) reset_pulse("rnd_rst");
        else step("rnd", iv, int'($urandom_range(0, 15)), ord);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
